// File: rtl/eda_strobe_pkg.sv
// Shared types for the strobe/visited bitmap: command opcodes, FSM states,
// neighbour bit positions and their (row, col) offsets.
package eda_strobe_pkg;

  typedef enum logic [1:0] {
    OP_SET       = 2'd0,
    OP_CLR_BIT   = 2'd1,
    OP_CLEAR_ALL = 2'd2,
    OP_FIND_NEXT = 2'd3
  } strb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2
  } strb_state_e;

  localparam int NB_UPLEFT    = 7;
  localparam int NB_UP        = 6;
  localparam int NB_UPRIGHT   = 5;
  localparam int NB_LEFT      = 4;
  localparam int NB_RIGHT     = 3;
  localparam int NB_DOWNLEFT  = 2;
  localparam int NB_DOWN      = 1;
  localparam int NB_DOWNRIGHT = 0;

  function automatic int nb_drow(input int b);
    case (b)
      NB_UPLEFT, NB_UP, NB_UPRIGHT:       return -1;
      NB_DOWNLEFT, NB_DOWN, NB_DOWNRIGHT: return 1;
      default:                            return 0;
    endcase
  endfunction

  function automatic int nb_dcol(input int b);
    case (b)
      NB_UPLEFT, NB_LEFT, NB_DOWNLEFT:    return -1;
      NB_UPRIGHT, NB_RIGHT, NB_DOWNRIGHT: return 1;
      default:                            return 0;
    endcase
  endfunction

endpackage

// File: rtl/eda_strobe_row_pe.sv
// Lowest-set-bit priority encoder for one map row: {hit, col}.
module eda_strobe_row_pe #(
  parameter int N       = 8,
  parameter int J_WIDTH = $clog2(N)
) (
  input  logic [N-1:0]       row,
  output logic               hit,
  output logic [J_WIDTH-1:0] col
);

  always_comb begin
    hit = 1'b0;
    col = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (row[j]) begin
        hit = 1'b1;
        col = J_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/eda_strobe_map.sv
// M x N strobe/visited bitmap with command port, chunked clear, row-major
// find-next scan and registered 8-neighbour lookup.
// Optional population count output when EDA_STROBE_MAP_COUNT_EN is defined.
module eda_strobe_map
  import eda_strobe_pkg::*;
#(
  parameter int M           = 8,
  parameter int N           = 8,
  parameter int I_WIDTH     = $clog2(M),
  parameter int J_WIDTH     = $clog2(N),
  parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH,
  parameter int CLEAR_ROWS  = 2,
  parameter int INIT_ORIGIN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  nbr_req,
  input  logic [ADDR_WIDTH-1:0] nbr_addr,
  output logic                  nbr_vld,
  output logic [7:0]            nbr_strb,
  output logic                  rsp_valid,
  output logic                  rsp_found,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic [M-1:0][N-1:0]   strb_value
`ifdef EDA_STROBE_MAP_COUNT_EN
  ,
  output logic [$clog2(M*N+1)-1:0] strb_count
`endif
);

  localparam int NCH = (M + CLEAR_ROWS - 1) / CLEAR_ROWS;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  strb_state_e state, state_nxt;
  strb_op_e    op;
  logic [M-1:0][N-1:0]         map;
  logic [CW-1:0]               clr_idx;
  logic [I_WIDTH-1:0]          row_idx;
  logic                        accept, cmd_in_range, clr_last, scan_last;
  logic [I_WIDTH-1:0]          cmd_row, nbr_row;
  logic [J_WIDTH-1:0]          cmd_col, nbr_col, scan_col;
  logic                        scan_hit;
  logic [M-1:0]                row_hit;
  logic [M-1:0][J_WIDTH-1:0]   row_col;
  logic [7:0]                  nbr_next;

  assign op         = strb_op_e'(cmd_op);
  assign accept     = cmd_valid & cmd_ready;
  assign cmd_row    = cmd_addr[ADDR_WIDTH-1:J_WIDTH];
  assign cmd_col    = cmd_addr[J_WIDTH-1:0];
  assign nbr_row    = nbr_addr[ADDR_WIDTH-1:J_WIDTH];
  assign nbr_col    = nbr_addr[J_WIDTH-1:0];
  assign cmd_in_range = (int'(cmd_row) < M) && (int'(cmd_col) < N);
  assign clr_last   = (clr_idx == CW'(NCH - 1));
  assign scan_last  = (row_idx == I_WIDTH'(M - 1));
  assign strb_value = map;

  // One encoder per row; the scan just selects the current row's result.
  for (genvar g = 0; g < M; g++) begin : g_row
    eda_strobe_row_pe #(.N(N), .J_WIDTH(J_WIDTH)) u_pe (
      .row(map[g]),
      .hit(row_hit[g]),
      .col(row_col[g])
    );
  end

  always_comb begin
    scan_hit = 1'b0;
    scan_col = '0;
    for (int i = 0; i < M; i++) begin
      if (i == int'(row_idx)) begin
        scan_hit = row_hit[i];
        scan_col = row_col[i];
      end
    end
  end

  // Neighbours falling outside the image keep their default of 1 (visited).
  always_comb begin
    nbr_next = 8'hFF;
    if ((int'(nbr_row) < M) && (int'(nbr_col) < N)) begin
      for (int b = 0; b < 8; b++) begin
        for (int i = 0; i < M; i++) begin
          for (int j = 0; j < N; j++) begin
            if ((i == int'(nbr_row) + nb_drow(b)) && (j == int'(nbr_col) + nb_dcol(b)))
              nbr_next[b] = map[i][j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && op == OP_CLEAR_ALL)      state_nxt = ST_CLEAR;
        else if (accept && op == OP_FIND_NEXT) state_nxt = ST_SCAN;
      end
      ST_CLEAR: if (clr_last) state_nxt = ST_IDLE;
      ST_SCAN:  if (scan_hit || scan_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map       <= '0;
      map[0][0] <= (INIT_ORIGIN != 0);
      clr_idx   <= '0;
      row_idx   <= '0;
      rsp_valid <= 1'b0;
      rsp_found <= 1'b0;
      rsp_addr  <= '0;
      rsp_err   <= 1'b0;
      nbr_vld   <= 1'b0;
      nbr_strb  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= accept && (op == OP_SET || op == OP_CLR_BIT) && !cmd_in_range;
      nbr_vld   <= nbr_req;
      if (nbr_req) nbr_strb <= nbr_next;
      case (state)
        ST_IDLE: begin
          clr_idx <= '0;
          row_idx <= '0;
          if (accept && cmd_in_range && (op == OP_SET || op == OP_CLR_BIT)) begin
            for (int i = 0; i < M; i++)
              for (int j = 0; j < N; j++)
                if (i == int'(cmd_row) && j == int'(cmd_col)) map[i][j] <= (op == OP_SET);
          end
        end
        ST_CLEAR: begin
          for (int i = 0; i < M; i++)
            if (i / CLEAR_ROWS == int'(clr_idx)) map[i] <= '0;
          // Origin re-seed must land after the row-0 clear, hence the ordering.
          if (clr_last) begin
            if (INIT_ORIGIN != 0) map[0][0] <= 1'b1;
            rsp_valid <= 1'b1;
          end
          clr_idx <= clr_idx + CW'(1);
        end
        ST_SCAN: begin
          if (scan_hit) begin
            rsp_valid <= 1'b1;
            rsp_found <= 1'b1;
            rsp_addr  <= {row_idx, scan_col};
          end else if (scan_last) begin
            rsp_valid <= 1'b1;
            rsp_found <= 1'b0;
            rsp_addr  <= '0;
          end
          row_idx <= row_idx + I_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef EDA_STROBE_MAP_COUNT_EN
  localparam int CNT_W = $clog2(M*N+1);
  logic cmd_bit;

  always_comb begin
    cmd_bit = 1'b0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        if (i == int'(cmd_row) && j == int'(cmd_col)) cmd_bit = map[i][j];
  end

  always_ff @(posedge clk) begin
    if (reset)
      strb_count <= CNT_W'(INIT_ORIGIN != 0);
    else if (state == ST_CLEAR && clr_last)
      strb_count <= CNT_W'(INIT_ORIGIN != 0);
    else if (accept && cmd_in_range && op == OP_SET && !cmd_bit)
      strb_count <= strb_count + CNT_W'(1);
    else if (accept && cmd_in_range && op == OP_CLR_BIT && cmd_bit)
      strb_count <= strb_count - CNT_W'(1);
  end
`endif

endmodule
